// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory read port plus the decode handshake.
// master = fetch controller, slave = memory/decode side.
interface instr_fetch_ctrl_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
);
  logic [INS_ADDRESS-1:0] imem_ra;
  logic [INS_W-1:0]       imem_rd;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INS_W-1:0]       instr;
  logic [INS_ADDRESS-1:0] instr_pc;

  modport master (
    output imem_ra,
    input  imem_rd,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_ra,
    output imem_rd,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction
// memory, buffers {pc, word} pairs in a small FIFO and hands them to decode.
//
// state  | meaning
// RUN    | fetching whenever the buffer has room (or is being popped)
// HALTED | halt seen; no fetch this cycle or the cycle halt drops
// STALL  | buffer full and decode not accepting
module instr_fetch_ctrl #(
  parameter int          INS_ADDRESS = 9,
  parameter int          INS_W       = 32,
  parameter int          FIFO_DEPTH  = 2,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_ctrl_if.master     bus,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  output logic                   misalign_err,
  output logic [15:0]            fetch_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [INS_ADDRESS-1:0] RESET_PC_V = RESET_PC[INS_ADDRESS-1:0];

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t                 state;
  logic [INS_ADDRESS-1:0] pc;
  logic [INS_W-1:0]       fifo_data [FIFO_DEPTH];
  logic [INS_ADDRESS-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic empty;
  logic full;
  logic pop;
  logic push;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  assign bus.imem_ra     = pc;
  assign bus.instr_valid = ~empty;
  assign bus.instr       = empty ? '0 : fifo_data[rd_ptr];
  assign bus.instr_pc    = empty ? '0 : fifo_pc[rd_ptr];

  // A redirect cancels both sides of the buffer for the cycle; pop is
  // masked below so a coincident accept is discarded along with the flush.
  assign pop  = ~empty & bus.instr_ready;
  assign push = (state != HALTED) & ~halt & ~redirect_valid & (~full | pop);

  // Sequencer state, PC, buffer pointers and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pc           <= RESET_PC_V;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      if (halt)
        state <= HALTED;
      else if (state == HALTED || redirect_valid)
        state <= RUN;
      else if (full && !pop)
        state <= STALL;
      else
        state <= RUN;

      if (redirect_valid) begin
        pc     <= {redirect_pc[INS_ADDRESS-1:2], 2'b00};
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        if (redirect_pc[1:0] != 2'b00)
          misalign_err <= 1'b1;
      end else begin
        if (push) begin
          fifo_data[wr_ptr] <= bus.imem_rd;
          fifo_pc[wr_ptr]   <= pc;
          wr_ptr            <= wr_ptr + PTR_W'(1);
          pc                <= pc + INS_ADDRESS'(4);
          if (fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a vector table walked one clock per row,
// followed by hand-written sequences for reset/redirect overlap and halt release.
module tb_instr_fetch_ctrl;
  localparam int AW = 9;
  localparam int DW = 32;

  typedef struct {
    logic          rst;
    logic          hlt;
    logic          rdy;
    logic          rv;
    logic [AW-1:0] rpc;
    logic          e_valid;
    logic [DW-1:0] e_instr;
    logic [AW-1:0] e_ipc;
    logic [AW-1:0] e_ra;
    logic          e_mis;
    logic [15:0]   e_fc;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          halt = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          misalign_err;
  logic [15:0]   fetch_count;

  logic [DW-1:0] imem [128];
  vec_t          vq[$];
  int            checks = 0;
  int            errors = 0;

  instr_fetch_ctrl_if #(.INS_ADDRESS(AW), .INS_W(DW)) bus ();

  assign bus.imem_rd = imem[bus.imem_ra[AW-1:2]];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .INS_ADDRESS(AW),
    .INS_W(DW),
    .FIFO_DEPTH(2),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .halt(halt),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic rst, input logic hlt, input logic rdy, input logic rv,
                         input logic [AW-1:0] rpc, input logic ev, input logic [DW-1:0] ei,
                         input logic [AW-1:0] eipc, input logic [AW-1:0] era,
                         input logic emis, input logic [15:0] efc);
    vec_t v;
    v.rst = rst; v.hlt = hlt; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_valid = ev; v.e_instr = ei; v.e_ipc = eipc; v.e_ra = era;
    v.e_mis = emis; v.e_fc = efc;
    vq.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic hlt, input logic rdy, input logic rv,
                       input logic [AW-1:0] rpc);
    reset = rst; halt = hlt; bus.instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [DW-1:0] ei,
                         input logic [AW-1:0] eipc, input logic [AW-1:0] era,
                         input logic emis, input logic [15:0] efc);
    chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(ev));
    chk({tag, " instr"}, bus.instr, ei);
    chk({tag, " instr_pc"}, 32'(bus.instr_pc), 32'(eipc));
    chk({tag, " imem_ra"}, 32'(bus.imem_ra), 32'(era));
    chk({tag, " misalign_err"}, 32'(misalign_err), 32'(emis));
    chk({tag, " fetch_count"}, 32'(fetch_count), 32'(efc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    logic          got;

    for (int i = 0; i < 128; i++) imem[i] = 32'h1300_0000 + 32'(i);
    imem[0] = 32'h0000_7033;
    imem[1] = 32'h0010_0093;
    imem[2] = 32'h0020_8113;
    imem[3] = 32'h0031_0193;
    imem[4] = 32'h0041_8213;
    imem[8] = 32'h0032_0433;

    //      rst   hlt   rdy   rv    rpc      ev    instr          ipc      ra       mis   fc
    add_vec(1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0000_0000, 9'h000, 9'h000, 1'b0, 16'd0);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0000_7033, 9'h000, 9'h004, 1'b0, 16'd1);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0010_0093, 9'h004, 9'h008, 1'b0, 16'd2);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0020_8113, 9'h008, 9'h00C, 1'b0, 16'd3);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0031_0193, 9'h00C, 9'h010, 1'b0, 16'd4);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0000_0000, 9'h000, 9'h000, 1'b0, 16'd0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 32'h0000_7033, 9'h000, 9'h004, 1'b0, 16'd1);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 32'h0000_7033, 9'h000, 9'h008, 1'b0, 16'd2);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 32'h0000_7033, 9'h000, 9'h008, 1'b0, 16'd2);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0010_0093, 9'h004, 9'h00C, 1'b0, 16'd3);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0020_8113, 9'h008, 9'h010, 1'b0, 16'd4);
    add_vec(1'b0, 1'b0, 1'b1, 1'b1, 9'h020, 1'b0, 32'h0000_0000, 9'h000, 9'h020, 1'b0, 16'd4);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 32'h0032_0433, 9'h020, 9'h024, 1'b0, 16'd5);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 9'h023, 1'b0, 32'h0000_0000, 9'h000, 9'h020, 1'b1, 16'd5);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0032_0433, 9'h020, 9'h024, 1'b1, 16'd6);
    add_vec(1'b0, 1'b0, 1'b1, 1'b1, 9'h1FC, 1'b0, 32'h0000_0000, 9'h000, 9'h1FC, 1'b1, 16'd6);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h1300_007F, 9'h1FC, 9'h000, 1'b1, 16'd7);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0000_7033, 9'h000, 9'h004, 1'b1, 16'd8);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 32'h0000_7033, 9'h000, 9'h008, 1'b1, 16'd9);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0010_0093, 9'h004, 9'h008, 1'b1, 16'd9);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0000_0000, 9'h000, 9'h008, 1'b1, 16'd9);
    add_vec(1'b0, 1'b1, 1'b1, 1'b1, 9'h010, 1'b0, 32'h0000_0000, 9'h000, 9'h010, 1'b1, 16'd9);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0000_0000, 9'h000, 9'h010, 1'b1, 16'd9);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0000_0000, 9'h000, 9'h010, 1'b1, 16'd9);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0041_8213, 9'h010, 9'h014, 1'b1, 16'd10);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 32'h0041_8213, 9'h010, 9'h018, 1'b1, 16'd11);
    add_vec(1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0000_0000, 9'h000, 9'h000, 1'b0, 16'd0);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 32'h0000_7033, 9'h000, 9'h004, 1'b0, 16'd1);

    drive(1'b1, 1'b0, 1'b1, 1'b0, '0);
    #1;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].hlt, vq[i].rdy, vq[i].rv, vq[i].rpc);
      step();
      chk_all($sformatf("v%0d", i), vq[i].e_valid, vq[i].e_instr, vq[i].e_ipc,
              vq[i].e_ra, vq[i].e_mis, vq[i].e_fc);
    end

    // Reset wins over a coincident misaligned redirect.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 9'h023);
    step();
    chk_all("rst_vs_redirect", 1'b0, 32'h0, 9'h000, 9'h000, 1'b0, 16'd0);

    // Fill the buffer, then redirect while decode is accepting: pop discarded.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    chk_all("fill1", 1'b1, 32'h0000_7033, 9'h000, 9'h004, 1'b0, 16'd1);
    step();
    chk_all("fill2", 1'b1, 32'h0000_7033, 9'h000, 9'h008, 1'b0, 16'd2);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9'h020);
    step();
    chk_all("flush_full", 1'b0, 32'h0, 9'h000, 9'h020, 1'b0, 16'd2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step();
    chk_all("target", 1'b1, 32'h0032_0433, 9'h020, 9'h024, 1'b0, 16'd3);
    step();
    chk_all("after_target", 1'b1, 32'h1300_0009, 9'h024, 9'h028, 1'b0, 16'd4);

    // Halt with a full buffer: drain two, then idle with PC held.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    chk_all("halt_fill", 1'b1, 32'h1300_0009, 9'h024, 9'h02C, 1'b0, 16'd5);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    step();
    chk_all("halt_drain1", 1'b1, 32'h1300_000A, 9'h028, 9'h02C, 1'b0, 16'd5);
    step();
    chk_all("halt_drain2", 1'b0, 32'h0, 9'h000, 9'h02C, 1'b0, 16'd5);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 9'h010);
    step();
    chk_all("halt_redirect", 1'b0, 32'h0, 9'h000, 9'h010, 1'b0, 16'd5);

    // Release halt and wait (bounded) for the redirect target.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.instr_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("halt_release_valid", 32'(got), 32'd1);
    chk_all("halt_release", 1'b1, 32'h0041_8213, 9'h010, 9'h014, 1'b0, 16'd6);

    // Head must hold steady under backpressure.
    held = bus.instr;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stable%0d instr", k), bus.instr, 32'h0041_8213);
      chk($sformatf("stable%0d instr_pc", k), 32'(bus.instr_pc), 32'h010);
    end
    chk("stable_vs_first", bus.instr, held);
    chk("stable fetch_count", 32'(fetch_count), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
